ctr_block_packer: RTL and testbench
===================================

Name: ctr_block_packer

Overview:
Parametrised successor to the single-width plaintext FIFO in the AES datapath. It accepts WORD_W-bit plaintext words from the AHB slave side and packs them into BLOCK_W-bit blocks. Each block is tagged with its own CTR-mode counter block (nonce plus running index) and buffered in a DEPTH-entry first-word-fall-through (FWFT) FIFO. A valid/ready port feeds the encryption core, and a flush packs a partial final block with a byte count.

Parameters:
WORD_W, 32, input word width; must divide BLOCK_W
BLOCK_W, 128, AES block width
DEPTH, 4, FIFO entries (>=2)
CTR_W, 32, low bits of counter block that increment; upper BLOCK_W-CTR_W bits fixed

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
clear  in  1  synchronous soft clear
nonce_in  in  BLOCK_W  initial counter block
nonce_load  in  1  load nonce_in into counter register
word_in  in  WORD_W  plaintext word
word_valid  in  1  word_in valid
word_ready  out  1  packer can accept word
flush  in  1  close current partial block
blk_data  out  BLOCK_W  head block plaintext
blk_ctr  out  BLOCK_W  head block counter block
blk_last  out  1  head block closed by flush
blk_nbytes  out  $clog2(BLOCK_W/8)+1  valid bytes in head block
blk_valid  out  1  FIFO not empty
blk_ready  in  1  core consumes head block
count  out  $clog2(DEPTH+1)  occupied entries
overflow_err  out  1  sticky: word offered while not ready

Behaviour:
- Reset (nRst low, async): FIFO empty, word index 0, counter 0, FSM NO_NONCE, all outputs 0.
- FSM states:
  - NO_NONCE: word_ready=0.
  - ACCEPT: normal operation.
  - FLUSH_WAIT: flush pending; word_ready=0.
- Transitions:
  - Any state -> ACCEPT on nonce_load.
  - ACCEPT -> FLUSH_WAIT on flush with a partial block and FIFO full.
  - FLUSH_WAIT -> ACCEPT when the partial block is pushed.
  - clear -> NO_NONCE from any state.
- word_ready in ACCEPT: (widx != BLOCK_WORDS-1) || (count < DEPTH), using registered count only. There is no combinational path from blk_ready.
- Word placement: word k of a block goes to bits [BLOCK_W-1-k*WORD_W -: WORD_W] (first word in the MSBs).
- Full block push: on accepting word BLOCK_WORDS-1, the block is written to the FIFO next edge with ctr = current counter, last=0, nbytes=BLOCK_W/8. widx returns to 0.
- Counter update: after each push, ctr[CTR_W-1:0] += 1 modulo 2^CTR_W. Upper bits are unchanged (wrap, no carry out).
- Flush with widx>0:
  - Pushes the partial block, zero-padded, last=1, nbytes=widx*WORD_W/8.
  - The counter increments; widx returns to 0.
- Flush with widx==0 and no word accepted that cycle: ignored.
- Flush and word_valid in the same cycle: the word is accepted first, then flush applies.
  - If that word completes the block: last=1, nbytes=BLOCK_W/8.
- Flush while FIFO full: enter FLUSH_WAIT and push on the first cycle count<DEPTH.
- Output side: FWFT; blk_* reflect the head entry; pop when blk_valid && blk_ready.
- Push and pop in the same cycle: count unchanged. A push at count==DEPTH never occurs (gated).
- nonce_load same cycle as push: the pushed block uses the old counter; the counter register takes nonce_in without increment.
- nonce_load mid-block: allowed; applies from the next push.
- overflow_err: set on word_valid && !word_ready; the word is dropped. Sticky until clear or reset.
- clear: empties FIFO, widx=0, drops pending flush, clears overflow_err, state NO_NONCE.
  - clear has priority over all same-cycle events.

Decomposition:
- Package aes_pkg:
  - AES_BLOCK_W=128.
  - typedef block_t (logic [127:0]).
  - typedef packed struct fifo_entry_t {data, ctr, last, nbytes}.
  - typedef enum packer_state_t {NO_NONCE, ACCEPT, FLUSH_WAIT}.
- Sub-module: block_fifo, parametrised (WIDTH, DEPTH). It provides FWFT storage, wrap-around read/write pointers, count, clear, and uses the same clk/nRst.

Test Plan:
- Reset, then word_valid=1 without nonce_load -> word_ready=0, overflow_err=1, count=0.
- nonce_in=0x...0000_FFFF_FFFF, load; write words 0x11111111,0x22222222,0x33333333,0x44444444 -> blk_data=0x11111111_22222222_33333333_44444444, blk_ctr low32=0xFFFFFFFF. Next block ctr low32=0x00000000 with upper bits unchanged.
- Write 2 words then flush -> blk_nbytes=8, blk_last=1, low 64 bits zero, counter advanced by 1.
- blk_ready=0, push DEPTH blocks -> count=DEPTH; word_ready drops when widx=3. A 5th attempt at widx 3 sets overflow_err.
- Flush while full with widx=1 -> FLUSH_WAIT, word_ready=0. One pop -> partial block pushed next cycle, count returns to DEPTH.
- Simultaneous push and pop at count=2 -> count stays 2. clear asserted with flush and word_valid -> count=0, state NO_NONCE, nothing pushed.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared types for the AES plaintext packing path.
//   AES_BLOCK_W  : native AES block width
//   block_t      : one AES block
//   fifo_entry_t : one buffered block {plaintext, counter block, last, nbytes}
//   packer_state_t : packer control states
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_NB_W    = $clog2(AES_BLOCK_W/8) + 1;

   typedef logic [AES_BLOCK_W-1:0] block_t;

   typedef struct packed {
      block_t                data;
      block_t                ctr;
      logic                  last;
      logic [AES_NB_W-1:0]   nbytes;
   } fifo_entry_t;

   typedef enum logic [1:0] {
      NO_NONCE   = 2'd0,
      ACCEPT     = 2'd1,
      FLUSH_WAIT = 2'd2
   } packer_state_t;

endpackage

// File: rtl/ctr_block_packer_if.sv
// ---------------------------------------------------------------------------
// ctr_block_packer_if
//   Bundles the packer's control, word-input and block-output signals.
//   master : the side driving words/control and consuming blocks
//   slave  : the packer itself
//   Control : clear, nonce_in, nonce_load, flush
//   Word in : word_in, word_valid, word_ready
//   Block out: blk_data, blk_ctr, blk_last, blk_nbytes, blk_valid, blk_ready
//   Status  : count, overflow_err
// ---------------------------------------------------------------------------
interface ctr_block_packer_if #(
   parameter int WORD_W  = 32,
   parameter int BLOCK_W = 128,
   parameter int DEPTH   = 4
);
   localparam int NB_W  = $clog2(BLOCK_W/8) + 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic                clear;
   logic [BLOCK_W-1:0]  nonce_in;
   logic                nonce_load;
   logic [WORD_W-1:0]   word_in;
   logic                word_valid;
   logic                word_ready;
   logic                flush;
   logic [BLOCK_W-1:0]  blk_data;
   logic [BLOCK_W-1:0]  blk_ctr;
   logic                blk_last;
   logic [NB_W-1:0]     blk_nbytes;
   logic                blk_valid;
   logic                blk_ready;
   logic [CNT_W-1:0]    count;
   logic                overflow_err;

   modport master (
      output clear, nonce_in, nonce_load, word_in, word_valid, flush, blk_ready,
      input  word_ready, blk_data, blk_ctr, blk_last, blk_nbytes, blk_valid,
             count, overflow_err
   );

   modport slave (
      input  clear, nonce_in, nonce_load, word_in, word_valid, flush, blk_ready,
      output word_ready, blk_data, blk_ctr, blk_last, blk_nbytes, blk_valid,
             count, overflow_err
   );
endinterface

// File: rtl/ctr_block_packer_block_fifo.sv
// ---------------------------------------------------------------------------
// block_fifo
//   First-word-fall-through FIFO with wrap-around pointers (any DEPTH >= 2).
//   clk, nRst : clock, async active-low reset
//   i_clear   : synchronous empty, wins over push/pop
//   i_push/i_wdata : write (ignored when full)
//   i_pop     : consume head (ignored when empty)
//   o_rdata   : head entry, zero while empty
//   o_valid   : not empty
//   o_count   : occupied entries
// ---------------------------------------------------------------------------
module block_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       nRst,
   input  logic                       i_clear,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_rdata,
   output logic                       o_valid,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr, r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push, w_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_push = i_push && (r_count != DEPTH_C);
   assign w_pop  = i_pop  && (r_count != '0);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk) begin
      if (w_push && !i_clear) r_mem[r_wptr] <= i_wdata;
   end

   assign o_valid = (r_count != '0);
   assign o_rdata = o_valid ? r_mem[r_rptr] : '0;
   assign o_count = r_count;
endmodule

// File: rtl/ctr_block_packer.sv
// ---------------------------------------------------------------------------
// ctr_block_packer
//   Packs WORD_W plaintext words into BLOCK_W blocks (first word in MSBs),
//   tags each block with its CTR-mode counter block and buffers it in a
//   DEPTH-entry FWFT FIFO. A flush closes a partial block, zero-padded,
//   with last=1 and its valid byte count.
//   clk, nRst : clock, async active-low reset
//   bus       : ctr_block_packer_if slave (control, words in, blocks out,
//               count, sticky overflow_err)
// ---------------------------------------------------------------------------
module ctr_block_packer
   import aes_pkg::*;
#(
   parameter int WORD_W  = 32,
   parameter int BLOCK_W = AES_BLOCK_W,
   parameter int DEPTH   = 4,
   parameter int CTR_W   = 32
) (
   input  logic         clk,
   input  logic         nRst,
   ctr_block_packer_if.slave bus
);
   localparam int BLOCK_WORDS = BLOCK_W / WORD_W;
   localparam int WIDX_W      = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam int NB_W        = $clog2(BLOCK_W/8) + 1;
   localparam int CNT_W       = $clog2(DEPTH+1);
   localparam int ENT_W       = 2*BLOCK_W + 1 + NB_W;
   localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(BLOCK_WORDS-1);
   localparam logic [NB_W-1:0]   FULL_NB  = NB_W'(BLOCK_W/8);
   localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);

   packer_state_t       r_state, w_state_nxt;
   logic [WIDX_W-1:0]   r_widx, w_widx_acc;
   logic [BLOCK_W-1:0]  r_buf, r_ctr, w_blk;
   logic                r_ovf;
   logic [CNT_W-1:0]    w_count;
   logic                w_space, w_ready, w_accept, w_complete;
   logic                w_flush_req, w_push, w_last;
   logic [NB_W-1:0]     w_nbytes;
   logic [ENT_W-1:0]    w_wr_ent, w_rd_ent;
   logic                w_rd_valid;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) r_state <= NO_NONCE;
      else       r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   // A nonce load wins over parking a flush; that flush is then dropped.
   always_comb begin
      w_state_nxt = r_state;
      if (bus.clear)
         w_state_nxt = NO_NONCE;
      else if (bus.nonce_load)
         w_state_nxt = ACCEPT;
      else begin
         case (r_state)
            ACCEPT:     if (w_flush_req && !w_space) w_state_nxt = FLUSH_WAIT;
            FLUSH_WAIT: if (w_space)                 w_state_nxt = ACCEPT;
            default:    w_state_nxt = r_state;
         endcase
      end
   end

   // ---------------- FSM: outputs / push control ----------------
   // Everything here looks at the registered count only, so blk_ready
   // never reaches word_ready or push combinationally.
   always_comb begin
      w_space     = (w_count < DEPTH_C);
      w_ready     = (r_state == ACCEPT) && ((r_widx != LAST_IDX) || w_space);
      w_accept    = bus.word_valid && w_ready;
      w_complete  = w_accept && (r_widx == LAST_IDX);
      // Only meaningful for partial blocks (w_complete low).
      w_widx_acc  = r_widx + WIDX_W'(w_accept);
      w_flush_req = ((r_state == ACCEPT) && bus.flush && !w_complete && (w_widx_acc != '0))
                 || (r_state == FLUSH_WAIT);
      w_push      = !bus.clear && (w_complete || (w_flush_req && w_space));
      w_last      = w_complete ? bus.flush : 1'b1;
      w_nbytes    = w_complete ? FULL_NB : NB_W'(w_widx_acc) * NB_W'(WORD_W/8);
   end

   // Block under construction: a fresh block starts from zero so the
   // unwritten tail of a flushed block is zero padding.
   always_comb begin
      w_blk = (r_widx == '0) ? '0 : r_buf;
      if (w_accept) begin
         for (int k = 0; k < BLOCK_WORDS; k++) begin
            if (r_widx == WIDX_W'(k)) w_blk[BLOCK_W-1-k*WORD_W -: WORD_W] = bus.word_in;
         end
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_widx <= '0;
         r_buf  <= '0;
         r_ctr  <= '0;
         r_ovf  <= 1'b0;
      end else if (bus.clear) begin
         r_widx <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_push)        r_widx <= '0;
         else if (w_accept) r_widx <= r_widx + WIDX_W'(1);
         if (w_accept) r_buf <= w_blk;
         // A same-cycle push already captured the old counter.
         if (bus.nonce_load) r_ctr <= bus.nonce_in;
         else if (w_push)    r_ctr[CTR_W-1:0] <= r_ctr[CTR_W-1:0] + CTR_W'(1);
         if (bus.word_valid && !w_ready) r_ovf <= 1'b1;
      end
   end

   assign w_wr_ent = {w_blk, r_ctr, w_last, w_nbytes};

   block_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .nRst    (nRst),
      .i_clear (bus.clear),
      .i_push  (w_push),
      .i_wdata (w_wr_ent),
      .i_pop   (bus.blk_ready),
      .o_rdata (w_rd_ent),
      .o_valid (w_rd_valid),
      .o_count (w_count)
   );

   assign bus.word_ready   = w_ready;
   assign bus.blk_valid    = w_rd_valid;
   assign bus.blk_data     = w_rd_ent[ENT_W-1 -: BLOCK_W];
   assign bus.blk_ctr      = w_rd_ent[NB_W+BLOCK_W -: BLOCK_W];
   assign bus.blk_last     = w_rd_ent[NB_W];
   assign bus.blk_nbytes   = w_rd_ent[NB_W-1:0];
   assign bus.count        = w_count;
   assign bus.overflow_err = r_ovf;
endmodule

// File: tb/tb_ctr_block_packer.sv
module tb_ctr_block_packer;
   import aes_pkg::*;

   localparam int WORD_W  = 32;
   localparam int BLOCK_W = 128;
   localparam int DEPTH   = 4;
   localparam int CTR_W   = 32;
   localparam int BW      = BLOCK_W / WORD_W;

   logic clk = 1'b0;
   logic nRst = 1'b0;
   always #5 clk = ~clk;

   ctr_block_packer_if #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .DEPTH(DEPTH)) bus ();

   ctr_block_packer #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .DEPTH(DEPTH), .CTR_W(CTR_W)) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: queue of expected entries plus the words of the open block.
   fifo_entry_t        m_q[$];
   logic [WORD_W-1:0]  m_words[$];
   logic [BLOCK_W-1:0] m_ctr = '0;
   bit m_loaded = 0, m_fwait = 0, m_ovf = 0;

   task automatic chk(input string tag, input logic [BLOCK_W-1:0] obs, input logic [BLOCK_W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_ready();
      return m_loaded && !m_fwait && (m_words.size() != BW-1 || m_q.size() < DEPTH);
   endfunction

   function automatic fifo_entry_t m_make(input bit last);
      fifo_entry_t e;
      e.data = '0;
      foreach (m_words[i]) e.data[BLOCK_W-1-i*WORD_W -: WORD_W] = m_words[i];
      e.ctr    = m_ctr;
      e.last   = last;
      e.nbytes = AES_NB_W'(m_words.size() * (WORD_W/8));
      return e;
   endfunction

   task automatic check_state();
      chk("count", BLOCK_W'(bus.count), BLOCK_W'(m_q.size()));
      chk("blk_valid", BLOCK_W'(bus.blk_valid), BLOCK_W'(m_q.size() > 0));
      chk("overflow_err", BLOCK_W'(bus.overflow_err), BLOCK_W'(m_ovf));
      if (m_q.size() > 0) begin
         chk("blk_data", bus.blk_data, m_q[0].data);
         chk("blk_ctr", bus.blk_ctr, m_q[0].ctr);
         chk("blk_last", BLOCK_W'(bus.blk_last), BLOCK_W'(m_q[0].last));
         chk("blk_nbytes", BLOCK_W'(bus.blk_nbytes), BLOCK_W'(m_q[0].nbytes));
      end
   endtask

   // One clock: inputs are already driven (called at negedge).
   task automatic cyc();
      bit rdy, i_clr, i_nl, i_wv, i_fl, i_br, pop, push;
      logic [BLOCK_W-1:0] i_nonce;
      logic [WORD_W-1:0]  i_wd;
      int pre;
      fifo_entry_t e;
      rdy = m_ready();
      chk("word_ready", BLOCK_W'(bus.word_ready), BLOCK_W'(rdy));
      i_clr = bus.clear; i_nl = bus.nonce_load; i_nonce = bus.nonce_in;
      i_wv = bus.word_valid; i_wd = bus.word_in; i_fl = bus.flush; i_br = bus.blk_ready;
      pre = m_q.size();
      pop = i_br && (pre > 0);
      push = 0;
      e = '0;
      @(posedge clk);
      if (i_clr) begin
         m_q.delete(); m_words.delete();
         m_loaded = 0; m_fwait = 0; m_ovf = 0;
      end else begin
         if (i_wv && !rdy) m_ovf = 1;
         if (i_wv && rdy) m_words.push_back(i_wd);
         if (m_words.size() == BW) begin
            e = m_make(i_fl); push = 1;
         end else if (m_fwait) begin
            if (pre < DEPTH) begin e = m_make(1); push = 1; m_fwait = 0; end
         end else if (m_loaded && i_fl && m_words.size() > 0) begin
            if (pre < DEPTH) begin e = m_make(1); push = 1; end
            else m_fwait = 1;
         end
         if (pop) void'(m_q.pop_front());
         if (push) begin
            m_q.push_back(e);
            m_words.delete();
            m_ctr[CTR_W-1:0] = m_ctr[CTR_W-1:0] + 1;
         end
         if (i_nl) begin m_ctr = i_nonce; m_loaded = 1; m_fwait = 0; end
      end
      @(negedge clk);
      check_state();
   endtask

   task automatic idle();
      bus.clear = 0; bus.nonce_load = 0; bus.word_valid = 0;
      bus.flush = 0; bus.blk_ready = 0;
   endtask

   task automatic wr(input logic [WORD_W-1:0] w);
      bus.word_valid = 1; bus.word_in = w;
      cyc();
      bus.word_valid = 0;
   endtask

   initial begin
      idle();
      bus.word_in  = '0;
      bus.nonce_in = '0;
      nRst = 0;
      repeat (2) @(negedge clk);
      // Reset state
      chk("rst_word_ready", BLOCK_W'(bus.word_ready), '0);
      chk("rst_count", BLOCK_W'(bus.count), '0);
      chk("rst_blk_valid", BLOCK_W'(bus.blk_valid), '0);
      chk("rst_blk_data", bus.blk_data, '0);
      chk("rst_blk_ctr", bus.blk_ctr, '0);
      chk("rst_blk_last_nb", BLOCK_W'({bus.blk_last, bus.blk_nbytes}), '0);
      chk("rst_ovf", BLOCK_W'(bus.overflow_err), '0);
      nRst = 1;
      @(negedge clk);

      // Word offered before any nonce
      wr(32'hDEADBEEF);
      chk("ovf_no_nonce", BLOCK_W'(bus.overflow_err), 1);
      chk("count_no_nonce", BLOCK_W'(bus.count), 0);
      bus.clear = 1; cyc(); bus.clear = 0;

      // Nonce with low word about to wrap
      bus.nonce_in = 128'hA5A5A5A5_01234567_00000000_FFFFFFFF;
      bus.nonce_load = 1; cyc(); bus.nonce_load = 0;
      wr(32'h11111111); wr(32'h22222222); wr(32'h33333333); wr(32'h44444444);
      chk("blk1_data", bus.blk_data, 128'h11111111_22222222_33333333_44444444);
      chk("blk1_ctr", bus.blk_ctr, 128'hA5A5A5A5_01234567_00000000_FFFFFFFF);
      chk("blk1_nbytes", BLOCK_W'(bus.blk_nbytes), 16);
      for (int i = 0; i < BW; i++) wr($urandom);
      bus.blk_ready = 1; cyc(); bus.blk_ready = 0;
      chk("blk2_ctr_wrap", bus.blk_ctr, 128'hA5A5A5A5_01234567_00000000_00000000);
      bus.blk_ready = 1; cyc(); bus.blk_ready = 0;

      // Partial flush
      wr(32'hAAAAAAAA); wr(32'hBBBBBBBB);
      bus.flush = 1; cyc(); bus.flush = 0;
      chk("partial_nbytes", BLOCK_W'(bus.blk_nbytes), 8);
      chk("partial_last", BLOCK_W'(bus.blk_last), 1);
      chk("partial_data", bus.blk_data, 128'hAAAAAAAA_BBBBBBBB_00000000_00000000);
      chk("partial_ctr", bus.blk_ctr, 128'hA5A5A5A5_01234567_00000000_00000001);
      bus.blk_ready = 1; cyc(); bus.blk_ready = 0;

      // Fill FIFO, then flush while full
      for (int i = 0; i < DEPTH*BW; i++) wr($urandom);
      chk("full_count", BLOCK_W'(bus.count), DEPTH);
      wr(32'h55555555);
      bus.flush = 1; cyc(); bus.flush = 0;
      chk("fwait_word_ready", BLOCK_W'(bus.word_ready), 0);
      chk("fwait_count", BLOCK_W'(bus.count), DEPTH);
      bus.blk_ready = 1; cyc(); bus.blk_ready = 0;
      chk("fwait_pop_count", BLOCK_W'(bus.count), DEPTH-1);
      cyc();
      chk("fwait_push_count", BLOCK_W'(bus.count), DEPTH);

      // Full FIFO: last word slot blocked
      for (int i = 0; i < BW-1; i++) wr($urandom);
      chk("full_last_slot_ready", BLOCK_W'(bus.word_ready), 0);
      wr(32'h66666666);
      chk("full_overflow", BLOCK_W'(bus.overflow_err), 1);

      // Simultaneous push and pop at count 2
      bus.clear = 1; cyc(); bus.clear = 0;
      bus.nonce_load = 1; bus.nonce_in = {$urandom, $urandom, $urandom, $urandom}; cyc(); bus.nonce_load = 0;
      for (int i = 0; i < 2*BW; i++) wr($urandom);
      for (int i = 0; i < BW-1; i++) wr($urandom);
      bus.blk_ready = 1; wr($urandom); bus.blk_ready = 0;
      chk("push_pop_count", BLOCK_W'(bus.count), 2);

      // clear beats flush and word in the same cycle
      wr($urandom);
      bus.clear = 1; bus.flush = 1; bus.word_valid = 1; bus.word_in = $urandom;
      cyc();
      idle();
      chk("clear_count", BLOCK_W'(bus.count), 0);
      chk("clear_word_ready", BLOCK_W'(bus.word_ready), 0);
      cyc();
      bus.nonce_load = 1; cyc(); bus.nonce_load = 0;
      for (int i = 0; i < BW; i++) wr($urandom);

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         bus.clear      = ($urandom_range(99) == 0);
         bus.nonce_load = ($urandom_range(19) == 0);
         bus.nonce_in   = {$urandom, $urandom, $urandom,
                           ($urandom_range(1) == 1) ? 32'hFFFFFFFE : $urandom};
         bus.word_valid = ($urandom_range(2) != 0);
         bus.word_in    = $urandom;
         bus.flush      = ($urandom_range(7) == 0);
         bus.blk_ready  = ($urandom_range(2) == 0);
         cyc();
      end
      idle();
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
